// File: rtl/mem_bist_ctrl_pkg.sv
// rtl/mem_bist_ctrl_pkg.sv - shared state encoding and test pattern function
// Purpose: FSM state type for the memory test controller and the BIST pattern
//          P(a) = a*mult (truncated by the caller), inverted in phase 1.
// Ports:   none (package).
package mem_test_pkg;

  typedef enum logic [2:0] {
    IDLE,
    M_ADDR,
    M_RD,
    M_WR,
    B_WR,
    B_RD,
    B_CMP,
    B_END
  } state_t;

  function automatic logic [31:0] pat(input logic [31:0] a, input logic phase,
                                      input logic [31:0] mult);
    logic [31:0] p;
    p = a * mult;
    return phase ? ~p : p;
  endfunction

endpackage

// File: rtl/mem_bist_ctrl_if.sv
// rtl/mem_bist_ctrl_if.sv - DPRAM port bundle between controller and memory
// Purpose: groups the memory address, write data, read data and strobes.
// Ports:   master (controller) drives A, din, rd, wr and reads dout;
//          slave (memory) is the mirror image.
interface mem_bist_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              rd;
  logic              wr;

  modport master (output A, din, rd, wr, input dout);
  modport slave  (input A, din, rd, wr, output dout);
endinterface

// File: rtl/mem_bist_ctrl_pat_gen.sv
// rtl/mem_bist_ctrl_pat_gen.sv - combinational expected-data generator
// Purpose: E(a, phase) = phase ? ~P(a) : P(a), P(a) = (a*PAT_MULT) mod 2**DATA_W.
// Ports:   addr (in, ADDR_W+1), phase (in), pattern (out, DATA_W).
module mem_pat_gen
  import mem_test_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int PAT_MULT = 15
) (
  input  logic [ADDR_W:0]   addr,
  input  logic              phase,
  output logic [DATA_W-1:0] pattern
);

  assign pattern = DATA_W'(pat(32'(addr), phase, 32'(PAT_MULT)));

endmodule

// File: rtl/mem_bist_ctrl.sv
// rtl/mem_bist_ctrl.sv - manual read/write and BIST controller for the DPRAM
// Purpose: manual single reads/writes from board buttons, or a two-phase
//          write/read-compare sweep with pass/fail, first failing address and
//          a saturating error count.
// Ports:   clk, ar (async active-high reset); bist_mode, addr_btn, rd_btn,
//          wr_btn, uin (board inputs); mem (memory master port);
//          busy, done, pass, fail, disp, fail_addr, err_cnt (status outputs).
module mem_bist_ctrl
  import mem_test_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 7,
  parameter int PAT_MULT = 15,
  parameter int ERR_W    = 8
) (
  input  logic                  clk,
  input  logic                  ar,
  input  logic                  bist_mode,
  input  logic                  addr_btn,
  input  logic                  rd_btn,
  input  logic                  wr_btn,
  input  logic [DATA_W-1:0]     uin,
  mem_bist_ctrl_if.master       mem,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [DATA_W-1:0]     disp,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [ERR_W-1:0]      err_cnt
);

  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W:0] LAST     = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W+1)'(1);
  localparam logic [CW-1:0]   W_LAST   = CW'(RD_LAT - 1);
  localparam logic [CW-1:0]   W_ONE    = CW'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t              state_q, state_d;
  logic [2:0]          btn_q;
  logic [2:0]          btn_edge;
  logic [ADDR_W:0]     addr_q, addr_d, addr_inc;
  logic                phase_q, phase_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic                miss_q, miss_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;
  logic                pass_q, pass_d, fail_q, fail_d, done_q, done_d;
  logic [DATA_W-1:0]   disp_q, disp_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0]   exp_data;

  // bit 2 = addr, bit 1 = rd, bit 0 = wr
  assign btn_edge = {addr_btn, rd_btn, wr_btn} & ~btn_q;
  assign addr_inc = addr_q + ADDR_ONE;

  mem_pat_gen #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .PAT_MULT(PAT_MULT)
  ) u_pat (
    .addr   (addr_q),
    .phase  (phase_q),
    .pattern(exp_data)
  );

  always_ff @(posedge clk or posedge ar) begin
    if (ar) begin
      state_q <= IDLE;
      btn_q   <= '0;
      addr_q  <= '0;
      phase_q <= 1'b0;
      wcnt_q  <= '0;
      miss_q  <= 1'b0;
      err_q   <= '0;
      faddr_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
      disp_q  <= '0;
      a_q     <= '0;
      din_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      btn_q   <= {addr_btn, rd_btn, wr_btn};
      addr_q  <= addr_d;
      phase_q <= phase_d;
      wcnt_q  <= wcnt_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      faddr_q <= faddr_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
      disp_q  <= disp_d;
      a_q     <= a_d;
      din_q   <= din_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    miss_d  = miss_q;
    err_d   = err_q;
    faddr_d = faddr_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    done_d  = done_q;
    disp_d  = disp_q;
    a_d     = a_q;
    din_d   = din_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (!bist_mode) begin
          if (btn_edge[2]) begin
            state_d = M_ADDR;
            done_d  = 1'b0;
          end else if (btn_edge[1]) begin
            state_d = M_RD;
            done_d  = 1'b0;
            rd_d    = 1'b1;
          end else if (btn_edge[0]) begin
            state_d = M_WR;
            done_d  = 1'b0;
            din_d   = uin;
          end
        end else if (btn_edge[2]) begin
          state_d = B_WR;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          err_d   = '0;
          faddr_d = '0;
          done_d  = 1'b0;
          phase_d = 1'b0;
          addr_d  = '0;
        end
      end
      M_ADDR: begin
        a_d     = uin[ADDR_W-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      M_RD: begin
        if (wcnt_q == W_LAST) begin
          disp_d  = mem.dout;
          rd_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + W_ONE;
        end
      end
      M_WR: begin
        // first cycle raises wr, second cycle drops it and finishes
        if (wcnt_q == '0) begin
          wr_d   = 1'b1;
          wcnt_d = W_ONE;
        end else begin
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      B_WR: begin
        // two cycles per address so wr can never stay high back to back
        if (wcnt_q == '0) begin
          a_d    = addr_q[ADDR_W-1:0];
          din_d  = exp_data;
          wr_d   = 1'b1;
          wcnt_d = W_ONE;
        end else begin
          wr_d   = 1'b0;
          wcnt_d = '0;
          if (addr_q == LAST) begin
            addr_d  = '0;
            a_d     = '0;
            rd_d    = 1'b1;
            state_d = B_RD;
          end else begin
            addr_d = addr_inc;
          end
        end
      end
      B_RD: begin
        if (wcnt_q == W_LAST) begin
          miss_d  = (mem.dout != exp_data);
          rd_d    = 1'b0;
          state_d = B_CMP;
        end else begin
          wcnt_d = wcnt_q + W_ONE;
        end
      end
      B_CMP: begin
        if (miss_q) begin
          if (err_q != '1) err_d = err_q + ERR_ONE;
          if (err_q == '0) faddr_d = addr_q[ADDR_W-1:0];
        end
        wcnt_d = '0;
        if (addr_q == LAST) begin
          addr_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            state_d = B_WR;
          end else begin
            state_d = B_END;
          end
        end else begin
          addr_d  = addr_inc;
          a_d     = addr_inc[ADDR_W-1:0];
          rd_d    = 1'b1;
          state_d = B_RD;
        end
      end
      B_END: begin
        pass_d  = (err_q == '0);
        fail_d  = (err_q != '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.A     = a_q;
  assign mem.din   = din_q;
  assign mem.rd    = rd_q;
  assign mem.wr    = wr_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign disp      = disp_q;
  assign fail_addr = faddr_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// tb/tb_mem_bist_ctrl.sv - self-checking bench for mem_bist_ctrl
module tb_mem_bist_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 7;

  logic clk = 1'b0;
  logic ar;
  logic bist_mode, addr_btn, rd_btn, wr_btn;
  logic [DATA_W-1:0] uin;
  logic busy, done, pass, fail;
  logic [DATA_W-1:0] disp;
  logic [ADDR_W-1:0] fail_addr;
  logic [7:0] err_cnt;

  mem_bist_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m ();

  mem_bist_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .PAT_MULT(15), .ERR_W(8)
  ) dut (
    .clk(clk), .ar(ar), .bist_mode(bist_mode), .addr_btn(addr_btn),
    .rd_btn(rd_btn), .wr_btn(wr_btn), .uin(uin), .mem(m),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .disp(disp),
    .fail_addr(fail_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // fault injection for the memory model
  logic        f_all = 1'b0;
  logic        f_en = 1'b0;
  int          f_addr = 0;
  logic [15:0] f_mask = 16'h0;

  function automatic logic [15:0] fmask(input int a);
    if (f_all) return 16'hFFFF;
    if (f_en && a == f_addr) return f_mask;
    return 16'h0000;
  endfunction

  function automatic logic [15:0] model_e(input int a, input int ph);
    logic [15:0] p;
    p = 16'((a * 15) % 65536);
    return (ph != 0) ? ~p : p;
  endfunction

  // memory: write stores data with stuck bits forced low; registered read
  logic [15:0] mem_arr [0:DEPTH-1];
  always @(posedge clk) begin
    if (m.wr) mem_arr[m.A] <= m.din & ~fmask(int'(m.A));
    if (m.rd) m.dout <= mem_arr[m.A];
  end

  // access scoreboard
  logic in_bist = 1'b0;
  int   wk = 0, rk = 0, run = 0;
  logic prev_rd = 1'b0, prev_wr = 1'b0;

  always @(negedge clk) begin
    if (ar) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
      run = 0;
    end else begin
      if (m.rd || m.wr) check("rd_wr_exclusive", 32'(m.rd & m.wr), 32'd0);
      if (m.wr) check("wr_single_cycle", 32'(prev_wr), 32'd0);
      if (m.wr && !prev_wr) begin
        if (in_bist) begin
          check("bist_wr_addr", 32'(m.A), 32'(wk % DEPTH));
          check("bist_wr_data", 32'(m.din), 32'(model_e(wk % DEPTH, wk / DEPTH)));
        end
        wk++;
      end
      if (m.rd && !prev_rd) begin
        if (in_bist) check("bist_rd_addr", 32'(m.A), 32'(rk % DEPTH));
        rk++;
        run = 0;
      end
      if (m.rd) run++;
      if (!m.rd && prev_rd) check("rd_length", 32'(run), 32'(RD_LAT));
      prev_rd = m.rd;
      prev_wr = m.wr;
    end
  end

  task automatic model_bist(output int errs, output int fa);
    logic [15:0] e;
    errs = 0;
    fa = 0;
    for (int ph = 0; ph < 2; ph++)
      for (int a = 0; a < DEPTH; a++) begin
        e = model_e(a, ph);
        if ((e & ~fmask(a)) != e) begin
          if (errs == 0) fa = a;
          if (errs < 255) errs++;
        end
      end
  endtask

  task automatic run_bist(input logic all0, input logic en, input int fa_in,
                          input logic [15:0] mask);
    int exp_err, exp_fa, cyc;
    f_all = all0; f_en = en; f_addr = fa_in; f_mask = mask;
    wk = 0; rk = 0;
    in_bist = 1'b1;
    bist_mode = 1'b1;
    addr_btn = 1'b1;
    @(negedge clk);
    addr_btn = 1'b0;
    check("bist_start_busy", 32'(busy), 32'd1);
    check("bist_start_clr_done", 32'(done), 32'd0);
    check("bist_start_clr_pass", 32'(pass), 32'd0);
    check("bist_start_clr_fail", 32'(fail), 32'd0);
    check("bist_start_clr_err", 32'(err_cnt), 32'd0);
    check("bist_start_clr_faddr", 32'(fail_addr), 32'd0);
    cyc = 0;
    while (!(done && !busy) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
    end
    check("bist_done", 32'(done), 32'd1);
    model_bist(exp_err, exp_fa);
    check("bist_pass", 32'(pass), 32'(exp_err == 0));
    check("bist_fail", 32'(fail), 32'(exp_err != 0));
    check("bist_err_cnt", 32'(err_cnt), 32'(exp_err));
    check("bist_fail_addr", 32'(fail_addr), 32'(exp_fa));
    check("bist_writes", 32'(wk), 32'(2 * DEPTH));
    check("bist_reads", 32'(rk), 32'(2 * DEPTH));
    in_bist = 1'b0;
    bist_mode = 1'b0;
    @(negedge clk);
  endtask

  int r0;

  initial begin
    ar = 1'b1;
    bist_mode = 1'b0; addr_btn = 1'b0; rd_btn = 1'b0; wr_btn = 1'b0;
    uin = '0;
    for (int i = 0; i < DEPTH; i++) mem_arr[i] = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_A", 32'(m.A), 32'd0);
    check("rst_rd_wr", 32'({m.rd, m.wr}), 32'd0);
    check("rst_status", 32'({busy, done, pass, fail}), 32'd0);
    check("rst_disp", 32'(disp), 32'd0);
    check("rst_err_faddr", 32'({err_cnt, fail_addr}), 32'd0);
    @(posedge clk); #1 ar = 1'b0;
    @(negedge clk);

    // manual address load
    uin = 16'h0005; addr_btn = 1'b1;
    @(negedge clk);
    addr_btn = 1'b0;
    check("maddr_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("maddr_A", 32'(m.A), 32'h5);
    check("maddr_done", 32'(done), 32'd1);
    check("maddr_idle", 32'(busy), 32'd0);

    // manual write: din, then one wr pulse, then done
    uin = 16'hBEEF; wr_btn = 1'b1;
    @(negedge clk);
    wr_btn = 1'b0;
    check("mwr_din", 32'(m.din), 32'hBEEF);
    check("mwr_wr_c1", 32'(m.wr), 32'd0);
    check("mwr_done_clr", 32'(done), 32'd0);
    @(negedge clk);
    check("mwr_wr_c2", 32'(m.wr), 32'd1);
    check("mwr_A", 32'(m.A), 32'h5);
    @(negedge clk);
    check("mwr_wr_c3", 32'(m.wr), 32'd0);
    check("mwr_done", 32'(done), 32'd1);
    check("mwr_idle", 32'(busy), 32'd0);

    // manual read: rd held RD_LAT cycles, then disp updated
    @(negedge clk);
    rd_btn = 1'b1;
    for (int i = 0; i < RD_LAT; i++) begin
      @(negedge clk);
      rd_btn = 1'b0;
      check("mrd_rd_high", 32'(m.rd), 32'd1);
    end
    @(negedge clk);
    check("mrd_rd_low", 32'(m.rd), 32'd0);
    check("mrd_disp", 32'(disp), 32'hBEEF);
    check("mrd_done", 32'(done), 32'd1);

    // held button: exactly one read
    repeat (2) @(negedge clk);
    r0 = rk;
    rd_btn = 1'b1;
    repeat (20) @(negedge clk);
    rd_btn = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_one_read", 32'(rk - r0), 32'd1);
    check("hold_disp", 32'(disp), 32'hBEEF);

    // asynchronous reset in the middle of a read
    rd_btn = 1'b1;
    @(negedge clk);
    rd_btn = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rd_active", 32'(m.rd), 32'd1);
    #1 ar = 1'b1;
    #1;
    check("arst_rd", 32'(m.rd), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_disp", 32'(disp), 32'd0);
    check("arst_A_done", 32'({m.A, done}), 32'd0);
    @(negedge clk);
    @(posedge clk); #1 ar = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'(busy), 32'd0);

    // BIST: ideal memory
    run_bist(1'b0, 1'b0, 0, 16'h0);
    check("ideal_pass", 32'(pass), 32'd1);
    check("ideal_err", 32'(err_cnt), 32'd0);

    // BIST: bit 3 stuck-at-0 at 0x2A (only phase 1 data has bit 3 set)
    run_bist(1'b0, 1'b1, 32'h2A, 16'h0008);
    check("stuck_fail", 32'(fail), 32'd1);
    check("stuck_faddr", 32'(fail_addr), 32'h2A);
    check("stuck_err", 32'(err_cnt), 32'd1);

    // BIST: every bit stuck-at-0 -> saturation, first miss at address 1
    run_bist(1'b1, 1'b0, 0, 16'h0);
    check("all0_fail", 32'(fail), 32'd1);
    check("all0_err_sat", 32'(err_cnt), 32'd255);
    check("all0_faddr", 32'(fail_addr), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
